// File: rtl/navic_pilot_corr_if.sv
// Handshake/data bundle between the chip-rate front end and the NavIC pilot correlator.
// The master drives control and chips; the slave (correlator) returns lock status and epoch results.
interface navic_pilot_corr_if;
  logic        ena;
  logic        start;
  logic [9:0]  g2_init;
  logic [9:0]  thresh;
  logic        chip_in;
  logic        chip_valid;
  logic        busy;
  logic        locked;
  logic        polarity;
  logic        corr_valid;
  logic [10:0] corr_count;
  logic [9:0]  code_phase;

  modport master (
    output ena, start, g2_init, thresh, chip_in, chip_valid,
    input  busy, locked, polarity, corr_valid, corr_count, code_phase
  );

  modport slave (
    input  ena, start, g2_init, thresh, chip_in, chip_valid,
    output busy, locked, polarity, corr_valid, corr_count, code_phase
  );
endinterface

// File: rtl/navic_pilot_corr.sv
// Serial code-phase acquisition/tracking correlator for the NavIC 1023-chip pilot Gold code.
// Define NAVIC_CORR_INVERT_DETECT_EN to also accept lock on the inverted code.
module navic_pilot_corr #(
  parameter int unsigned THRESH_DEF = 900,
  parameter int unsigned MISS_LIMIT = 3
) (
  input logic               clk,
  input logic               rst_n,
  navic_pilot_corr_if.slave bus
);

  localparam int unsigned MISS_W = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  // Bit i holds LFSR stage i+1, so bit 9 is stage 10 (the output tap).
  function automatic logic [9:0] g1_step(input logic [9:0] g);
    g1_step = {g[8:0], g[2] ^ g[9]};
  endfunction

  function automatic logic [9:0] g2_step(input logic [9:0] g);
    g2_step = {g[8:0], g[1] ^ g[2] ^ g[5] ^ g[7] ^ g[8] ^ g[9]};
  endfunction

  state_t            state_r;
  logic [9:0]        g1_r;
  logic [9:0]        g2_r;
  logic [9:0]        g2_init_r;
  logic [9:0]        thresh_r;
  logic [9:0]        cnt_r;
  logic [10:0]       acc_r;
  logic              slip_r;
  logic [MISS_W-1:0] miss_r;
  logic              ep_r;
  logic [10:0]       ep_count_r;
  logic              ep_hit_r;
  logic              ep_pol_r;
  logic              busy_r;
  logic              locked_r;
  logic              polarity_r;
  logic              corr_valid_r;
  logic [10:0]       corr_count_r;
  logic [9:0]        code_phase_r;

  logic              run_s;
  logic              accept_s;
  logic              skip_s;
  logic              local_chip_s;
  logic              match_s;
  logic [10:0]       total_s;
  logic              last_s;
  logic              norm_s;
  logic              inv_s;
  logic              hit_s;
  logic              pol_s;
  logic              slip_set_s;
  logic [9:0]        next_phase_s;

  // Chip acceptance, epoch total and the hit/slip decision taken on the last chip of an epoch.
  always_comb begin
    run_s        = bus.ena & bus.chip_valid & ~bus.start & (state_r != ST_IDLE);
    accept_s     = run_s & ~slip_r;
    skip_s       = run_s & slip_r;
    local_chip_s = g1_r[9] ^ g2_r[9];
    match_s      = (bus.chip_in == local_chip_s);
    total_s      = acc_r + {10'd0, match_s};
    last_s       = (cnt_r == 10'd1022);
    norm_s       = (total_s >= {1'b0, thresh_r});
`ifdef NAVIC_CORR_INVERT_DETECT_EN
    inv_s        = (total_s <= (11'd1023 - {1'b0, thresh_r}));
`else
    inv_s        = 1'b0;
`endif
    pol_s        = inv_s & ~norm_s;
    if (state_r == ST_LOCK) begin
      if (polarity_r) begin
        hit_s = inv_s;
      end else begin
        hit_s = norm_s;
      end
    end else begin
      hit_s = norm_s | inv_s;
    end
    case (state_r)
      ST_SEARCH: slip_set_s = ~hit_s;
      ST_LOCK:   slip_set_s = ~hit_s & (miss_r == MISS_LAST);
      default:   slip_set_s = 1'b0;
    endcase
    if (code_phase_r == 10'd1022) begin
      next_phase_s = 10'd0;
    end else begin
      next_phase_s = code_phase_r + 10'd1;
    end
  end

  // Sequencer: chip correlation, epoch close-out one cycle after the last chip, and the FSM.
  // The slip flag is armed on the last-chip edge so the very next valid chip is the one dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      g1_r         <= 10'h3FF;
      g2_r         <= 10'h3FF;
      g2_init_r    <= 10'h3FF;
      thresh_r     <= 10'(THRESH_DEF);
      cnt_r        <= 10'd0;
      acc_r        <= 11'd0;
      slip_r       <= 1'b0;
      miss_r       <= '0;
      ep_r         <= 1'b0;
      ep_count_r   <= 11'd0;
      ep_hit_r     <= 1'b0;
      ep_pol_r     <= 1'b0;
      busy_r       <= 1'b0;
      locked_r     <= 1'b0;
      polarity_r   <= 1'b0;
      corr_valid_r <= 1'b0;
      corr_count_r <= 11'd0;
      code_phase_r <= 10'd0;
    end else if (bus.ena) begin
      corr_valid_r <= 1'b0;
      if (bus.start) begin
        state_r      <= ST_SEARCH;
        busy_r       <= 1'b1;
        locked_r     <= 1'b0;
        polarity_r   <= 1'b0;
        g1_r         <= 10'h3FF;
        g2_r         <= bus.g2_init;
        g2_init_r    <= bus.g2_init;
        thresh_r     <= bus.thresh;
        cnt_r        <= 10'd0;
        acc_r        <= 11'd0;
        slip_r       <= 1'b0;
        miss_r       <= '0;
        ep_r         <= 1'b0;
        code_phase_r <= 10'd0;
      end else begin
        if (accept_s) begin
          if (last_s) begin
            cnt_r      <= 10'd0;
            acc_r      <= 11'd0;
            g1_r       <= 10'h3FF;
            g2_r       <= g2_init_r;
            ep_r       <= 1'b1;
            ep_count_r <= total_s;
            ep_hit_r   <= hit_s;
            ep_pol_r   <= pol_s;
            slip_r     <= slip_set_s;
          end else begin
            cnt_r      <= cnt_r + 10'd1;
            acc_r      <= total_s;
            g1_r       <= g1_step(g1_r);
            g2_r       <= g2_step(g2_r);
          end
        end else if (skip_s) begin
          slip_r <= 1'b0;
        end
        if (ep_r) begin
          ep_r         <= 1'b0;
          corr_valid_r <= 1'b1;
          corr_count_r <= ep_count_r;
          case (state_r)
            ST_SEARCH: begin
              if (ep_hit_r) begin
                state_r    <= ST_LOCK;
                locked_r   <= 1'b1;
                polarity_r <= ep_pol_r;
                miss_r     <= '0;
              end else begin
                code_phase_r <= next_phase_s;
              end
            end
            ST_LOCK: begin
              if (ep_hit_r) begin
                miss_r <= '0;
              end else if (miss_r == MISS_LAST) begin
                state_r      <= ST_SEARCH;
                locked_r     <= 1'b0;
                miss_r       <= '0;
                code_phase_r <= next_phase_s;
              end else begin
                miss_r <= miss_r + MISS_W'(1);
              end
            end
            default: begin
              state_r <= state_r;
            end
          endcase
        end
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.locked     = locked_r;
  assign bus.corr_valid = corr_valid_r;
  assign bus.corr_count = corr_count_r;
  assign bus.code_phase = code_phase_r;
`ifdef NAVIC_CORR_INVERT_DETECT_EN
  assign bus.polarity   = polarity_r;
`else
  assign bus.polarity   = 1'b0;
`endif

endmodule
